// File: rtl/mult_share_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types for the multiplier-sharing controller: operand/product widths,
// operand and product types, and the request record held in pipeline stage S1.
// No ports (package).
// -----------------------------------------------------------------------------
package mult_pkg;

    // Operand width is fixed by the 6-partial-product radix-4 core.
    localparam int OP_W = 11;
    localparam int P_W  = 22;

    typedef logic [OP_W-1:0] op_t;
    typedef logic [P_W-1:0]  prod_t;

    // Request record; id is wide enough for the largest supported NUM_REQ (8).
    typedef struct packed {
        op_t        a;
        op_t        b;
        logic [2:0] id;
    } mult_req_t;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_share_ctrl_if
// Request/result bus between NUM_REQ requesters, the result consumer and the
// multiplier-sharing controller.
//   master : requester/consumer side (drives req_valid, req_a, req_b, res_ready)
//   slave  : controller side (drives req_ready, res_*, busy, op_count)
// -----------------------------------------------------------------------------
interface mult_share_ctrl_if
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic                    res_valid;
    logic                    res_ready;
    prod_t                   res_p;
    logic [ID_W-1:0]         res_id;
    logic                    busy;
    logic [CNT_W-1:0]        op_count;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, res_id, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, res_id, busy, op_count
    );

endinterface

// File: rtl/mult_share_ctrl_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the lowest index at or after
// i_ptr+1 (mod N) whose request is set.
//   i_req   N      request vector
//   i_ptr   IDX_W  index granted last
//   o_grant N      one-hot grant (all zero when no request)
//   o_idx   IDX_W  encoded grant index
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // Rotating priority search; offset N wraps back to i_ptr itself last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl_core.sv
// -----------------------------------------------------------------------------
// mult_core
// Unsigned 11b x 11b -> 22b combinational multiplier. Behavioural model with
// the same port contract as the radix-4 booth + dadda_tree core.
//   i_a, i_b  OP_W  operands
//   o_p       P_W   full-width product
// -----------------------------------------------------------------------------
module mult_core
    import mult_pkg::*;
(
    input  op_t   i_a,
    input  op_t   i_b,
    output prod_t o_p
);

    assign o_p = P_W'(i_a) * P_W'(i_b);

endmodule

// File: rtl/mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// mult_share_ctrl
// Shares one combinational multiplier core among NUM_REQ requesters with
// round-robin arbitration and a 2-stage valid/ready pipeline (S1: operands +
// id, S2: product + id). One op/cycle throughput, 2-cycle latency.
//   i_clk  single clock, rising edge
//   i_rst  synchronous reset, active-high
//   bus    mult_share_ctrl_if.slave (requests in, results/status out)
// -----------------------------------------------------------------------------
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mult_share_ctrl_if.slave   bus
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_grant_oh;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_adv2;
    logic               w_can_take;
    logic               w_accept;
    mult_req_t          w_req;
    prod_t              w_core_p;
    op_t                w_a_arr [NUM_REQ];
    op_t                w_b_arr [NUM_REQ];

    logic [ID_W-1:0]    r_rr_ptr;
    mult_req_t          r_s1;
    logic               r_s1_valid;
    prod_t              r_s2_p;
    logic [ID_W-1:0]    r_s2_id;
    logic               r_s2_valid;
    logic [CNT_W-1:0]   r_op_count;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx)
    );

    mult_core u_core (
        .i_a (r_s1.a),
        .i_b (r_s1.b),
        .o_p (w_core_p)
    );

    // Pipeline advance conditions and the granted operand pair.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_a_arr[i] = bus.req_a[i*OP_W +: OP_W];
            w_b_arr[i] = bus.req_b[i*OP_W +: OP_W];
        end
        w_adv2     = !r_s2_valid || bus.res_ready;
        // S1 can take a new op when empty or when its content moves into S2.
        w_can_take = !r_s1_valid || w_adv2;
        w_accept   = w_can_take && (|bus.req_valid);
        w_req.a    = w_a_arr[w_grant_idx];
        w_req.b    = w_b_arr[w_grant_idx];
        w_req.id   = 3'(w_grant_idx);
    end

    assign bus.req_ready = w_grant_oh & {NUM_REQ{w_can_take}};
    assign bus.res_valid = r_s2_valid;
    assign bus.res_p     = r_s2_p;
    assign bus.res_id    = r_s2_id;
    assign bus.busy      = r_s1_valid | r_s2_valid;
    assign bus.op_count  = r_op_count;

    // Round-robin pointer: moves to the granted index only on acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_rr_ptr <= w_grant_idx;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Stage S1: captures the granted operands, empties when drained into S2.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1       <= w_req;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage S2: product register; holds its data while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_id    <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_p  <= w_core_p;
                r_s2_id <= r_s1.id[ID_W-1:0];
            end else begin
                r_s2_p  <= r_s2_p;
                r_s2_id <= r_s2_id;
            end
        end else begin
            r_s2_valid <= r_s2_valid;
        end
    end

    // Completed-result counter, wraps silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_count <= '0;
        end else if (r_s2_valid && bus.res_ready) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end else begin
            r_op_count <= r_op_count;
        end
    end

endmodule
